// File: rtl/trigger_capture_ctrl_if.sv
// Stream bundle between the trigger block, the capture sequencer and the
// sample buffer writer. The slave modport is the sequencer's view: it
// accepts sti_* samples and drives sto_* beats.
interface trigger_capture_ctrl_if #(
  parameter int SDW = 32,
  parameter int TEW = 8
);
  logic           sti_tready;
  logic           sti_tvalid;
  logic [TEW-1:0] sti_tevent;
  logic [SDW-1:0] sti_tdata;
  logic           sto_tready;
  logic           sto_tvalid;
  logic           sto_ttrig;
  logic           sto_tlast;
  logic [SDW-1:0] sto_tdata;

  modport master (
    output sti_tvalid, sti_tevent, sti_tdata, sto_tready,
    input  sti_tready, sto_tvalid, sto_ttrig, sto_tlast, sto_tdata
  );

  modport slave (
    input  sti_tvalid, sti_tevent, sti_tdata, sto_tready,
    output sti_tready, sto_tvalid, sto_ttrig, sto_tlast, sto_tdata
  );
endinterface

// File: rtl/trigger_capture_ctrl.sv
// Capture sequencer: forwards pre-trigger samples, waits for a masked event,
// then forwards post-trigger samples, tagging the trigger and final beats.
//
// state | meaning
// IDLE  | not armed, input samples accepted and dropped
// PRE   | forwarding pre-trigger samples, events ignored
// WAIT  | forwarding samples until one carries a masked event
// POST  | forwarding post-trigger samples, events ignored
// DONE  | capture complete, input dropped until re-armed
module trigger_capture_ctrl #(
  parameter int SDW = 32,
  parameter int TEW = 8,
  parameter int CNW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_arm,
  input  logic                 cfg_abort,
  input  logic [CNW-1:0]       cfg_pre,
  input  logic [CNW-1:0]       cfg_post,
  input  logic [TEW-1:0]       cfg_mask,
  trigger_capture_ctrl_if.slave bus,
  output logic [2:0]           sts_state,
  output logic                 sts_done,
  output logic [CNW-1:0]       sts_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [CNW-1:0] ONE = CNW'(1);

  state_t         state_q, state_d;
  logic [CNW-1:0] cnt_q, pre_q, post_q;
  logic [TEW-1:0] mask_q;
  logic           out_valid_q, out_trig_q, out_last_q;
  logic [SDW-1:0] out_data_q;
  logic           in_ready, active, xfer, hit, pre_end, post_end;
  logic           arm_ok, load, trig_beat, last_beat;

  assign active    = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
  assign xfer      = bus.sti_tvalid & in_ready;
  assign hit       = |(bus.sti_tevent & mask_q);
  // Terminal counts compare against count-1 so the counter never exceeds
  // the configured value and cannot wrap.
  assign pre_end   = (cnt_q == pre_q - ONE);
  assign post_end  = (cnt_q == post_q - ONE);
  assign arm_ok    = cfg_arm & ~cfg_abort & ((state_q == IDLE) || (state_q == DONE));
  assign trig_beat = (state_q == WAIT) & hit;
  assign last_beat = (trig_beat & (post_q == '0)) | ((state_q == POST) & post_end);
  // A sample accepted in the abort cycle is dropped so no tag leaks out.
  assign load      = xfer & active & ~cfg_abort;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides everything, including a same-cycle arm.
  always_comb begin
    state_d = state_q;
    if (cfg_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (cfg_arm) state_d = (cfg_pre == '0) ? WAIT : PRE;
        PRE:        if (xfer && pre_end) state_d = WAIT;
        WAIT:       if (xfer && hit) state_d = (post_q == '0) ? DONE : POST;
        POST:       if (xfer && post_end) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; the input is free-running when not capturing.
  always_comb begin
    in_ready       = active ? (~out_valid_q | bus.sto_tready) : 1'b1;
    bus.sti_tready = in_ready;
    sts_state      = state_q;
    sts_done       = (state_q == DONE);
    sts_cnt        = cnt_q;
  end

  // Configuration latch and pre/post sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      post_q <= '0;
      mask_q <= '0;
    end else if (cfg_abort) begin
      cnt_q <= '0;
    end else if (arm_ok) begin
      cnt_q  <= '0;
      pre_q  <= cfg_pre;
      post_q <= cfg_post;
      mask_q <= cfg_mask;
    end else if (xfer) begin
      case (state_q)
        PRE:     cnt_q <= pre_end ? '0 : cnt_q + ONE;
        WAIT:    if (hit) cnt_q <= '0;
        POST:    cnt_q <= cnt_q + ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Single output register stage; holds its beat while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_trig_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.sti_tdata;
      out_trig_q  <= trig_beat;
      out_last_q  <= last_beat;
    end else if (bus.sto_tready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.sto_tvalid = out_valid_q;
  assign bus.sto_tdata  = out_data_q;
  assign bus.sto_ttrig  = out_trig_q;
  assign bus.sto_tlast  = out_last_q;

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Directed bench for trigger_capture_ctrl: one task per scenario, each with
// hand-computed expected beats and status values.
module tb_trigger_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_arm = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [15:0] cfg_pre = '0;
  logic [15:0] cfg_post = '0;
  logic [7:0]  cfg_mask = '0;
  logic [2:0]  sts_state;
  logic        sts_done;
  logic [15:0] sts_cnt;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] src_data[$];
  logic [7:0]  src_ev[$];
  logic [31:0] cap_data[$];
  bit          cap_trig[$];
  bit          cap_last[$];
  bit          timeout;
  int          stall_err;

  trigger_capture_ctrl_if #(.SDW(32), .TEW(8)) bus ();

  trigger_capture_ctrl #(.SDW(32), .TEW(8), .CNW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_arm   (cfg_arm),
    .cfg_abort (cfg_abort),
    .cfg_pre   (cfg_pre),
    .cfg_post  (cfg_post),
    .cfg_mask  (cfg_mask),
    .bus       (bus),
    .sts_state (sts_state),
    .sts_done  (sts_done),
    .sts_cnt   (sts_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; pulses cfg_arm for one cycle.
  task automatic arm(input logic [15:0] pre, input logic [15:0] post, input logic [7:0] mask);
    cfg_pre  = pre;
    cfg_post = post;
    cfg_mask = mask;
    cfg_arm  = 1'b1;
    @(posedge clk); #1;
    cfg_arm  = 1'b0;
  endtask

  // Feeds src_* samples, records output beats, and notes any change of a
  // stalled beat. Inputs change at posedge+1, observation at negedge.
  task automatic run_stream(input logic [3:0] rpat);
    int idx;
    int cyc;
    bit stalled;
    bit acc;
    logic [33:0] held;
    idx = 0; cyc = 0; stalled = 0; held = '0;
    cap_data.delete(); cap_trig.delete(); cap_last.delete();
    timeout = 0; stall_err = 0;
    while (1) begin
      if (idx < src_data.size()) begin
        bus.sti_tvalid = 1'b1;
        bus.sti_tdata  = src_data[idx];
        bus.sti_tevent = src_ev[idx];
      end else begin
        bus.sti_tvalid = 1'b0;
        bus.sti_tdata  = '0;
        bus.sti_tevent = '0;
      end
      bus.sto_tready = rpat[cyc % 4];
      @(negedge clk);
      if (stalled && (!bus.sto_tvalid ||
          {bus.sto_tdata, bus.sto_ttrig, bus.sto_tlast} != held))
        stall_err++;
      if (bus.sto_tvalid && bus.sto_tready) begin
        cap_data.push_back(bus.sto_tdata);
        cap_trig.push_back(bus.sto_ttrig);
        cap_last.push_back(bus.sto_tlast);
      end
      stalled = bus.sto_tvalid && !bus.sto_tready;
      held    = {bus.sto_tdata, bus.sto_ttrig, bus.sto_tlast};
      acc     = bus.sti_tvalid && bus.sti_tready;
      if (acc) idx++;
      if (!acc && idx == src_data.size() && (!bus.sto_tvalid || bus.sto_tready)) break;
      cyc++;
      if (cyc > 200) begin
        timeout = 1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.sti_tvalid = 1'b0;
    bus.sto_tready = 1'b1;
    src_data.delete();
    src_ev.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.sto_tvalid, sts_state, sts_done, sts_cnt} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b state=%0d done=%0b cnt=%0d, want all 0",
               bus.sto_tvalid, sts_state, sts_done, sts_cnt);
    end
    n_checks++;
    if (bus.sti_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready: got %0b want 1", bus.sti_tready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // pre=3 post=2 mask=0x01, samples 1..10, events on samples 2 and 6.
  task automatic load_basic_stream();
    for (int k = 1; k <= 10; k++) begin
      src_data.push_back(32'h100 + 32'(k));
      src_ev.push_back((k == 2 || k == 6) ? 8'h01 : 8'h00);
    end
  endtask

  task automatic test_basic();
    logic [33:0] exp_b;
    arm(16'd3, 16'd2, 8'h01);
    n_checks++;
    if (sts_state !== 3'd1) begin
      n_fail++;
      $display("FAIL basic_arm_state: got %0d want 1", sts_state);
    end
    load_basic_stream();
    run_stream(4'b1111);
    n_checks++;
    if (timeout) begin n_fail++; $display("FAIL basic_timeout: stream did not drain"); end
    n_checks++;
    if (cap_data.size() !== 8) begin
      n_fail++;
      $display("FAIL basic_beat_count: got %0d want 8", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < 8; i++) begin
      exp_b = {32'h101 + 32'(i), (i == 5), (i == 7)};
      n_checks++;
      if ({cap_data[i], cap_trig[i], cap_last[i]} !== exp_b) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got data=%h trig=%0b last=%0b want data=%h trig=%0b last=%0b",
                 i, cap_data[i], cap_trig[i], cap_last[i], exp_b[33:2], exp_b[1], exp_b[0]);
      end
    end
    n_checks++;
    if (sts_state !== 3'd4 || sts_done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done: state=%0d done=%0b want 4/1", sts_state, sts_done);
    end
  endtask

  task automatic test_pre0_post0();
    arm(16'd0, 16'd0, 8'h80);
    n_checks++;
    if (sts_state !== 3'd2) begin
      n_fail++;
      $display("FAIL p0_arm_state: got %0d want 2", sts_state);
    end
    src_data.push_back(32'h0000_00A5);
    src_ev.push_back(8'h80);
    run_stream(4'b1111);
    n_checks++;
    if (timeout || cap_data.size() !== 1) begin
      n_fail++;
      $display("FAIL p0_beat_count: got %0d want 1 (timeout=%0b)", cap_data.size(), timeout);
    end else begin
      n_checks++;
      if ({cap_data[0], cap_trig[0], cap_last[0]} !== {32'h0000_00A5, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL p0_beat: got data=%h trig=%0b last=%0b want data=000000a5 trig=1 last=1",
                 cap_data[0], cap_trig[0], cap_last[0]);
      end
    end
    n_checks++;
    if (sts_state !== 3'd4 || sts_done !== 1'b1) begin
      n_fail++;
      $display("FAIL p0_done: state=%0d done=%0b want 4/1", sts_state, sts_done);
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] exp_b;
    arm(16'd3, 16'd2, 8'h01);
    load_basic_stream();
    run_stream(4'b1001);
    n_checks++;
    if (timeout) begin n_fail++; $display("FAIL bp_timeout: stream did not drain"); end
    n_checks++;
    if (stall_err !== 0) begin
      n_fail++;
      $display("FAIL bp_stall_stable: %0d stalled beats changed, want 0", stall_err);
    end
    n_checks++;
    if (cap_data.size() !== 8) begin
      n_fail++;
      $display("FAIL bp_beat_count: got %0d want 8", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < 8; i++) begin
      exp_b = {32'h101 + 32'(i), (i == 5), (i == 7)};
      n_checks++;
      if ({cap_data[i], cap_trig[i], cap_last[i]} !== exp_b) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got data=%h trig=%0b last=%0b want data=%h trig=%0b last=%0b",
                 i, cap_data[i], cap_trig[i], cap_last[i], exp_b[33:2], exp_b[1], exp_b[0]);
      end
    end
    n_checks++;
    if (sts_state !== 3'd4 || sts_done !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_done: state=%0d done=%0b want 4/1", sts_state, sts_done);
    end
  endtask

  task automatic test_abort_arm();
    logic [33:0] exp_b;
    arm(16'd2, 16'd1, 8'h01);
    src_data.push_back(32'h20); src_ev.push_back(8'h00);
    src_data.push_back(32'h21); src_ev.push_back(8'h00);
    run_stream(4'b1111);
    n_checks++;
    if (timeout || cap_data.size() !== 2 || sts_state !== 3'd2 || sts_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL ab_wait: beats=%0d state=%0d cnt=%0d want 2/2/0", cap_data.size(), sts_state, sts_cnt);
    end
    cfg_pre = 16'd0; cfg_post = 16'd0; cfg_mask = 8'h01;
    cfg_arm = 1'b1; cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_arm = 1'b0; cfg_abort = 1'b0;
    n_checks++;
    if (sts_state !== 3'd0 || sts_done !== 1'b0 || sts_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL ab_idle: state=%0d done=%0b cnt=%0d want 0/0/0", sts_state, sts_done, sts_cnt);
    end
    arm(16'd1, 16'd1, 8'h02);
    n_checks++;
    if (sts_state !== 3'd1) begin
      n_fail++;
      $display("FAIL ab_rearm_state: got %0d want 1", sts_state);
    end
    src_data.push_back(32'h30); src_ev.push_back(8'h02);
    src_data.push_back(32'h31); src_ev.push_back(8'h01);
    src_data.push_back(32'h32); src_ev.push_back(8'h02);
    src_data.push_back(32'h33); src_ev.push_back(8'h00);
    run_stream(4'b1111);
    n_checks++;
    if (timeout || cap_data.size() !== 4) begin
      n_fail++;
      $display("FAIL ab_beat_count: got %0d want 4 (timeout=%0b)", cap_data.size(), timeout);
    end
    for (int i = 0; i < cap_data.size() && i < 4; i++) begin
      exp_b = {32'h30 + 32'(i), (i == 2), (i == 3)};
      n_checks++;
      if ({cap_data[i], cap_trig[i], cap_last[i]} !== exp_b) begin
        n_fail++;
        $display("FAIL ab_beat%0d: got data=%h trig=%0b last=%0b want data=%h trig=%0b last=%0b",
                 i, cap_data[i], cap_trig[i], cap_last[i], exp_b[33:2], exp_b[1], exp_b[0]);
      end
    end
    n_checks++;
    if (sts_state !== 3'd4) begin
      n_fail++;
      $display("FAIL ab_done: state=%0d want 4", sts_state);
    end
  endtask

  task automatic test_arm_in_post();
    arm(16'd0, 16'd3, 8'h01);
    src_data.push_back(32'h40); src_ev.push_back(8'h01);
    src_data.push_back(32'h41); src_ev.push_back(8'h00);
    run_stream(4'b1111);
    n_checks++;
    if (timeout || cap_data.size() !== 2) begin
      n_fail++;
      $display("FAIL ap_first_count: got %0d want 2 (timeout=%0b)", cap_data.size(), timeout);
    end else begin
      n_checks++;
      if ({cap_trig[0], cap_last[0], cap_trig[1], cap_last[1]} !== 4'b1000) begin
        n_fail++;
        $display("FAIL ap_first_tags: got %b want 1000",
                 {cap_trig[0], cap_last[0], cap_trig[1], cap_last[1]});
      end
    end
    n_checks++;
    if (sts_state !== 3'd3 || sts_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL ap_post: state=%0d cnt=%0d want 3/1", sts_state, sts_cnt);
    end
    arm(16'd0, 16'd0, 8'h00);
    n_checks++;
    if (sts_state !== 3'd3 || sts_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL ap_ignored: state=%0d cnt=%0d want 3/1", sts_state, sts_cnt);
    end
    src_data.push_back(32'h42); src_ev.push_back(8'h00);
    src_data.push_back(32'h43); src_ev.push_back(8'h00);
    src_data.push_back(32'h44); src_ev.push_back(8'h00);
    run_stream(4'b1111);
    n_checks++;
    if (timeout || cap_data.size() !== 2) begin
      n_fail++;
      $display("FAIL ap_second_count: got %0d want 2 (timeout=%0b)", cap_data.size(), timeout);
    end else begin
      n_checks++;
      if ({cap_data[0], cap_last[0], cap_data[1], cap_last[1]} !== {32'h42, 1'b0, 32'h43, 1'b1}) begin
        n_fail++;
        $display("FAIL ap_second_beats: got %h/%0b %h/%0b want 00000042/0 00000043/1",
                 cap_data[0], cap_last[0], cap_data[1], cap_last[1]);
      end
    end
    n_checks++;
    if (sts_state !== 3'd4) begin
      n_fail++;
      $display("FAIL ap_done: state=%0d want 4", sts_state);
    end
  endtask

  task automatic test_reset_mid_post();
    arm(16'd0, 16'd5, 8'h01);
    bus.sti_tvalid = 1'b1; bus.sti_tdata = 32'h55; bus.sti_tevent = 8'h01; bus.sto_tready = 1'b1;
    @(posedge clk); #1;
    bus.sti_tdata = 32'h56; bus.sti_tevent = 8'h00;
    @(posedge clk); #1;
    bus.sti_tvalid = 1'b0; bus.sto_tready = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (sts_state !== 3'd3 || sts_cnt !== 16'd1 || bus.sto_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmp_pre: state=%0d cnt=%0d valid=%0b want 3/1/1", sts_state, sts_cnt, bus.sto_tvalid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.sto_tvalid !== 1'b0 || sts_state !== 3'd0 || sts_cnt !== 16'd0 || sts_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rmp_after: valid=%0b state=%0d cnt=%0d done=%0b want 0/0/0/0",
               bus.sto_tvalid, sts_state, sts_cnt, sts_done);
    end
    rst = 1'b0;
    bus.sto_tready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.sti_tvalid = 1'b0;
    bus.sti_tdata  = '0;
    bus.sti_tevent = '0;
    bus.sto_tready = 1'b1;
    test_reset();
    test_basic();
    test_pre0_post0();
    test_backpressure();
    test_abort_arm();
    test_arm_in_post();
    test_reset_mid_post();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_capture_ctrl.md
Name: trigger_capture_ctrl

Overview:
Capture sequencer placed after the trigger block and before the sample buffer writer. It arms an acquisition and forwards a configured number of pre-trigger samples. It then waits for a masked trigger event and forwards a configured number of post-trigger samples. Each forwarded beat is tagged with trigger and last flags so the buffer writer can close the capture.

Parameters:
SDW, 32, sample data width
TEW, 8, trigger event width (matches trigger block event vector)
CNW, 16, pre/post sample counter width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cfg_arm  input  1  single-cycle arm request
cfg_abort  input  1  single-cycle abort request
cfg_pre  input  CNW  pre-trigger sample count, latched on arm
cfg_post  input  CNW  post-trigger sample count (excluding trigger sample), latched on arm
cfg_mask  input  TEW  event bits that fire the trigger, latched on arm
sti_tready  output  1  input stream ready
sti_tvalid  input  1  input stream valid
sti_tevent  input  TEW  event vector for this sample
sti_tdata  input  SDW  sample data
sto_tready  input  1  output stream ready
sto_tvalid  output  1  output stream valid
sto_ttrig  output  1  beat is the trigger sample
sto_tlast  output  1  final beat of capture
sto_tdata  output  SDW  sample data
sts_state  output  3  current state encoding
sts_done  output  1  capture complete (level)
sts_cnt  output  CNW  current pre/post counter

Behaviour:
- Single clock. Reset is asynchronous and active-high; it forces state IDLE and clears all outputs and counters to 0.
- sts_state encoding: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
- Input transfer (xfer) = sti_tvalid & sti_tready.
- sti_tready = 1 in IDLE/DONE, where samples are accepted and dropped. In PRE/WAIT/POST, sti_tready = ~sto_tvalid | sto_tready.
- Output is one register stage. It loads on every xfer in PRE/WAIT/POST and has 1-cycle latency. sto_tvalid stays high until sto_tready. sto_tdata/ttrig/tlast hold stable while sto_tvalid & ~sto_tready.
- cfg_arm in IDLE or DONE:
  - latch cfg_pre/cfg_post/cfg_mask; clear cnt and sts_done;
  - go to PRE, or to WAIT if cfg_pre==0.
  - cfg_arm in any other state is ignored.
- PRE:
  - each xfer increments cnt;
  - the xfer that makes cnt==pre goes to WAIT and clears cnt;
  - events are ignored, so no trigger fires during pre-fill.
- WAIT:
  - an xfer with |(sti_tevent & mask) marks the beat sto_ttrig=1;
  - if post==0 the same beat has sto_tlast=1 and the next state is DONE, else the next state is POST with cnt=0;
  - non-matching xfers are forwarded untagged.
- POST:
  - each xfer increments cnt;
  - the xfer with cnt==post-1 sets sto_tlast=1 and goes to DONE;
  - further events are ignored.
- DONE: sts_done=1 and held until the next arm, abort or reset. The final beat may still be pending on the output and drains normally.
- cfg_abort in any state: next state IDLE, cnt cleared, sts_done cleared. A pending output beat is not dropped; it drains unchanged. No tlast is generated.
- cfg_arm and cfg_abort in the same cycle: abort wins.
- Counters are CNW bits and never wrap: the maximum count is 2**CNW-1, and state transitions occur on equality before overflow.
- sts_cnt mirrors the internal counter.

Test Plan:
- Reset mid-POST with sto_tvalid high -> next cycle sto_tvalid=0, sts_state=0, sts_cnt=0.
- Arm pre=3, post=2, mask=0x01; stream samples 1..10 with event bit0 on sample 2 and sample 6 -> sample 2 ignored. Output 1,2,3 untagged, then 4,5 untagged, then 6 with ttrig=1, then 7, then 8 with tlast=1. sts_done=1; samples 9,10 dropped.
- Arm pre=0, post=0, mask=0x80; first sample event=0x80 -> single beat with ttrig=1 and tlast=1, state DONE.
- Same as the pre=3/post=2 scenario with sto_tready toggling 1,0,0,1 -> no beat lost or duplicated, and sto_tdata stable while stalled.
- Abort asserted in WAIT together with arm -> state IDLE; later arm restarts from PRE with freshly latched cfg values.
- Arm asserted in POST -> ignored, and the capture completes with the originally latched post count.
